// File: rtl/fill_screen_pkg.sv
// Shared definitions for the full-screen fill block: FSM states and screen geometry.
package fill_screen_pkg;

  localparam int H_PIXELS = 160;
  localparam int V_PIXELS = 120;

  localparam logic [7:0] X_LAST = 8'(H_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(V_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    FILL = 3'b001,
    DONE = 3'b010
  } state_t;

endpackage

// File: rtl/fill_screen_if.sv
// Handshake and plot-port bundle between the controller, the fill block and the VGA adapter.
interface fill_screen_if;

  logic [2:0] colour;
  logic       start;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output colour, start,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  colour, start,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );

endinterface

// File: rtl/fill_screen_xy_scan_counter.sv
// Column-major pixel counter: y runs fastest, x advances when y wraps.
module xy_scan_counter
  import fill_screen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Holds at (159,119) once reached so the coordinates never leave the screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (enable && !last) begin
      if (y == Y_LAST) begin
        y <= '0;
        x <= x + 8'd1;
      end else begin
        y <= y + 7'd1;
      end
    end
  end

endmodule

// File: rtl/fill_screen.sv
// Full-screen fill: start/done handshake driving one VGA pixel write per clock.
module fill_screen
  import fill_screen_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fill_screen_if.slave bus
);

  state_t     present_state;
  state_t     next_state;
  logic [2:0] colour_q;
  logic       clear;
  logic       plot;
  logic       done;
  logic       last;
  logic [7:0] x;
  logic [6:0] y;

  xy_scan_counter u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .enable (plot),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      present_state <= IDLE;
      colour_q      <= '0;
    end else begin
      present_state <= next_state;
      if (present_state == IDLE && bus.start)
        colour_q <= bus.colour;
    end
  end

  // Dropping start mid-fill suppresses the write in that same cycle.
  always_comb begin
    next_state = present_state;
    clear      = 1'b0;
    plot       = 1'b0;
    done       = 1'b0;
    case (present_state)
      IDLE: begin
        clear = 1'b1;
        if (bus.start)
          next_state = FILL;
      end
      FILL: begin
        if (!bus.start) begin
          next_state = IDLE;
        end else begin
          plot = 1'b1;
          if (last)
            next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!bus.start)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.done       = done;
  assign bus.vga_plot   = plot;
  assign bus.vga_x      = x;
  assign bus.vga_y      = y;
  assign bus.vga_colour = colour_q;

endmodule

// File: tb/tb_fill_screen.sv
// Self-checking bench for fill_screen against a pixel-index scan model.
module tb_fill_screen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fill_screen_if bus ();

  fill_screen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: the k-th plotted pixel must be (k/120, k%120).
  bit [119:0] seen [160];
  int         k;
  int         bad;
  int         dup;
  int         bad_k, bad_x, bad_y, bad_c;
  int         after119_x, after119_y;
  int         last_x, last_y;

  task automatic run_fill(input logic [2:0] col, input int budget, input int stop_at,
                          output int plots, output int cycles, output bit done_seen);
    k = 0; bad = 0; dup = 0; bad_k = -1; bad_x = 0; bad_y = 0; bad_c = 0;
    after119_x = -1; after119_y = -1; last_x = -1; last_y = -1;
    for (int i = 0; i < 160; i++) seen[i] = '0;
    plots = 0;
    cycles = 0;
    done_seen = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.vga_plot === 1'b1) begin
        int ax, ay;
        ax = int'(bus.vga_x);
        ay = int'(bus.vga_y);
        if (ax !== k / 120 || ay !== k % 120 || bus.vga_colour !== col) begin
          if (bad == 0) begin
            bad_k = k; bad_x = ax; bad_y = ay; bad_c = int'(bus.vga_colour);
          end
          bad++;
        end
        if (ax < 160 && ay < 120) begin
          if (seen[ax][ay]) dup++;
          seen[ax][ay] = 1'b1;
        end
        if (k == 120) begin
          after119_x = ax; after119_y = ay;
        end
        last_x = ax; last_y = ay;
        k++;
        plots++;
        if (stop_at > 0 && plots == stop_at) return;
      end
      if (bus.done === 1'b1) begin
        done_seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_fill_result(input string tag, input logic [2:0] col, input int plots,
                                   input int cycles, input bit done_seen);
    int missing;
    missing = 0;
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        if (!seen[i][j]) missing++;
    total_cnt++;
    if (!(done_seen && cycles <= 19210))
      $display("FAIL %s_done_latency: done_seen=%0d cycles=%0d, required done by 19210", tag, done_seen, cycles);
    else pass_cnt++;
    total_cnt++;
    if (plots !== 19200) $display("FAIL %s_plot_count: got %0d, required 19200", tag, plots);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0)
      $display("FAIL %s_scan_seq: %0d bad pixels, first at k=%0d got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
               tag, bad, bad_k, bad_x, bad_y, bad_c, bad_k / 120, bad_k % 120, col);
    else pass_cnt++;
    total_cnt++;
    if (missing !== 0 || dup !== 0)
      $display("FAIL %s_coverage: missing=%0d dup=%0d, required 0/0", tag, missing, dup);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.colour = 3'b000;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (dut.present_state !== 3'b000) $display("FAIL reset_state: got %b, required 000", dut.present_state);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0 || bus.vga_plot !== 1'b0)
      $display("FAIL reset_outputs: done=%b plot=%b, required 0/0", bus.done, bus.vga_plot);
    else pass_cnt++;
    total_cnt++;
    if (bus.vga_colour !== 3'b000 || bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0)
      $display("FAIL reset_pixel: c=%b x=%0d y=%0d, required 0,0,0", bus.vga_colour, bus.vga_x, bus.vga_y);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_abort();
    int plots, cycles, waited;
    bit done_seen;
    logic [2:0] col;
    col = 3'($urandom_range(1, 7));
    bus.colour = col;
    bus.start = 1'b1;
    run_fill(col, 50, 0, plots, cycles, done_seen);
    total_cnt++;
    if (plots < 45 || bad !== 0)
      $display("FAIL abort_prefix: plots=%0d bad=%0d, required >=45 plots in scan order", plots, bad);
    else pass_cnt++;
    bus.start = 1'b0;
    waited = 0;
    while (waited < 5) begin
      @(negedge clk);
      waited++;
      if (dut.present_state === 3'b000) break;
    end
    total_cnt++;
    if (dut.present_state !== 3'b000 || bus.vga_plot !== 1'b0)
      $display("FAIL abort_idle: state=%b plot=%b after %0d cycles, required 000/0", dut.present_state, bus.vga_plot, waited);
    else pass_cnt++;
  endtask

  task automatic test_full_fill();
    int plots, cycles;
    bit done_seen;
    bit stray;
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.colour = 3'b101;
    @(negedge clk);
    rst_n = 1'b1;
    run_fill(3'b101, 19210, 0, plots, cycles, done_seen);
    check_fill_result("fill", 3'b101, plots, cycles, done_seen);
    total_cnt++;
    if (after119_x !== 1 || after119_y !== 0)
      $display("FAIL scan_wrap: after (0,119) got (%0d,%0d), required (1,0)", after119_x, after119_y);
    else pass_cnt++;
    total_cnt++;
    if (last_x !== 159 || last_y !== 119)
      $display("FAIL last_pixel: got (%0d,%0d), required (159,119)", last_x, last_y);
    else pass_cnt++;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.vga_plot !== 1'b0 || bus.done !== 1'b1) stray = 1'b1;
    end
    total_cnt++;
    if (stray) $display("FAIL done_hold: plot=%b done=%b, required plot 0, done held 1", bus.vga_plot, bus.done);
    else pass_cnt++;
  endtask

  task automatic test_done_release();
    int plots, cycles;
    bit done_seen;
    logic [2:0] col;
    bus.start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.done !== 1'b0 || dut.present_state !== 3'b000)
      $display("FAIL done_release: done=%b state=%b, required 0/000", bus.done, dut.present_state);
    else pass_cnt++;
    col = 3'($urandom_range(0, 7));
    bus.colour = col;
    bus.start = 1'b1;
    run_fill(col, 19210, 0, plots, cycles, done_seen);
    check_fill_result("refill", col, plots, cycles, done_seen);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_midfill_reset();
    int plots, cycles, target;
    bit done_seen;
    logic [2:0] col;
    target = $urandom_range(4000, 6000);
    col = 3'($urandom_range(1, 7));
    bus.colour = col;
    bus.start = 1'b1;
    run_fill(col, 19210, target, plots, cycles, done_seen);
    total_cnt++;
    if (plots !== target || bad !== 0)
      $display("FAIL midfill_prefix: plots=%0d bad=%0d, required %0d in order", plots, bad, target);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (dut.present_state !== 3'b000 || bus.vga_plot !== 1'b0 || bus.done !== 1'b0 ||
        bus.vga_colour !== 3'b000 || bus.vga_x !== 8'd0 || bus.vga_y !== 7'd0)
      $display("FAIL midfill_async_reset: state=%b plot=%b done=%b c=%b x=%0d y=%0d, required all 0",
               dut.present_state, bus.vga_plot, bus.done, bus.vga_colour, bus.vga_x, bus.vga_y);
    else pass_cnt++;
    @(negedge clk);
    col = 3'($urandom_range(0, 7));
    bus.colour = col;
    rst_n = 1'b1;
    run_fill(col, 5, 3, plots, cycles, done_seen);
    total_cnt++;
    if (plots !== 3 || bad !== 0)
      $display("FAIL midfill_restart: plots=%0d bad=%0d first_bad=(%0d,%0d), required 3 plots from (0,0)",
               plots, bad, bad_x, bad_y);
    else pass_cnt++;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.colour = 3'b000;
    test_reset();
    test_abort();
    test_full_fill();
    test_done_release();
    test_midfill_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
